// File: rtl/txn_circular_buffer_pkg.sv
// Shared definitions for the transactional circular buffer: error bit
// positions, transaction state encoding and a small control-decode helper.
package txn_cb_pkg;

  localparam int ERR_WIDTH = 5;

  // Sticky error bit positions in o_err
  localparam int ERR_OVR  = 0;  // write dropped because the buffer was full
  localparam int ERR_UNR  = 1;  // read requested with no committed data
  localparam int ERR_NEST = 2;  // begin while a transaction is already open
  localparam int ERR_IDLE = 3;  // commit or abort with no open transaction
  localparam int ERR_CONF = 4;  // more than one transaction control at once

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } txn_state_e;

  // True when at least two of the three transaction controls are high.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/txn_circular_buffer_if.sv
// Bus bundle between the packet producer / byte consumer side and the buffer.
//
// Handshake: o_rd_valid is the read-side valid and i_rd_en is the pop.
// A pop is taken only in a cycle where o_rd_valid is high; a pop while
// o_rd_valid is low is an underrun and changes nothing but o_err[1].
// Writes have no ready: the producer watches o_full / o_used, and a write
// refused for lack of space raises o_err[0] and is dropped.
interface txn_circular_buffer_if
  import txn_cb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  // Producer side
  logic                    i_txn_begin;
  logic                    i_txn_commit;
  logic                    i_txn_abort;
  logic                    i_wr_en;
  logic [DATA_WIDTH-1:0]   i_wr_data;
  // Consumer side
  logic                    i_rd_en;
  logic [DATA_WIDTH-1:0]   o_rd_data;
  logic                    o_rd_valid;
  // Status
  logic [ADDR_WIDTH:0]     o_count;
  logic [ADDR_WIDTH:0]     o_used;
  logic                    o_full;
  logic                    o_empty;
  logic                    o_almost_full;
  logic                    o_almost_empty;
  logic                    o_txn_open;
  logic                    i_clr_err;
  logic [ERR_WIDTH-1:0]    o_err;
  // Debug view of the transaction FSM
  txn_state_e              o_state;

  modport master (
    output i_txn_begin, i_txn_commit, i_txn_abort, i_wr_en, i_wr_data,
           i_rd_en, i_clr_err,
    input  o_rd_data, o_rd_valid, o_count, o_used, o_full, o_empty,
           o_almost_full, o_almost_empty, o_txn_open, o_err, o_state
  );

  modport slave (
    input  i_txn_begin, i_txn_commit, i_txn_abort, i_wr_en, i_wr_data,
           i_rd_en, i_clr_err,
    output o_rd_data, o_rd_valid, o_count, o_used, o_full, o_empty,
           o_almost_full, o_almost_empty, o_txn_open, o_err, o_state
  );

endinterface

// File: rtl/txn_circular_buffer_ram.sv
// Storage array: one synchronous write port, one asynchronous read port so
// the head entry is presented combinationally (first-word fall-through).
module circ_buf_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store on the clock edge when enabled
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/txn_circular_buffer.sv
// FWFT circular buffer with transactional writes. Writes made while a
// transaction is open land in memory but stay behind commit_ptr, so the
// reader cannot see them; commit moves commit_ptr up to wr_ptr, abort pulls
// wr_ptr back to commit_ptr. Outside a transaction every accepted write is
// committed on the spot.
module txn_circular_buffer
  import txn_cb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  txn_circular_buffer_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0]         AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Registered state
  txn_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   commit_ptr_q, commit_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           used_q, used_d;
  logic [ERR_WIDTH-1:0]    err_q, err_d;

  // Decoded controls
  logic                    ctrl_conflict;
  logic                    do_begin;
  logic                    do_commit;
  logic                    do_abort;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rd_data;

  // FSM side effects
  logic                    wr_direct;  // accepted write is committed immediately
  logic                    publish;    // open transaction is being committed
  logic                    rewind;     // open transaction is being aborted
  logic                    err_nest;
  logic                    err_idle;
  logic [ERR_WIDTH-1:0]    err_set;

  // Conflicting controls cancel one another; the write still goes ahead
  // under whatever state the FSM is currently in.
  assign ctrl_conflict = multi_hot3(bus.i_txn_begin, bus.i_txn_commit, bus.i_txn_abort);
  assign do_begin      = bus.i_txn_begin  & ~ctrl_conflict;
  assign do_commit     = bus.i_txn_commit & ~ctrl_conflict;
  assign do_abort      = bus.i_txn_abort  & ~ctrl_conflict;

  // A read frees a slot in the same cycle, so a write at full is accepted
  // alongside an accepted read.
  assign rd_acc = bus.i_rd_en & (count_q != '0);
  assign wr_acc = bus.i_wr_en & ((used_q < DEPTH_C) | rd_acc);

  // An aborted same-cycle write never needs to reach memory.
  assign mem_we = wr_acc & ~rewind & ~i_rst;

  // Transaction FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction FSM next state and the commit/abort/error strobes it drives
  always_comb begin
    state_d   = state_q;
    wr_direct = 1'b0;
    publish   = 1'b0;
    rewind    = 1'b0;
    err_nest  = 1'b0;
    err_idle  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A write together with begin already belongs to the new transaction
        wr_direct = ~do_begin;
        if (do_begin) begin
          state_d = ST_OPEN;
        end else if (do_commit || do_abort) begin
          err_idle = 1'b1;
        end
      end
      ST_OPEN: begin
        if (do_begin) begin
          err_nest = 1'b1;
        end else if (do_commit) begin
          publish = 1'b1;
          state_d = ST_IDLE;
        end else if (do_abort) begin
          rewind  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer and occupancy next state
  always_comb begin
    rd_ptr_d     = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d     = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    commit_ptr_d = commit_ptr_q;

    used_d = used_q;
    if (wr_acc && !rd_acc) begin
      used_d = used_q + CNT_ONE;
    end else if (!wr_acc && rd_acc) begin
      used_d = used_q - CNT_ONE;
    end

    count_d = count_q;
    if ((wr_acc && wr_direct) && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (!(wr_acc && wr_direct) && rd_acc) begin
      count_d = count_q - CNT_ONE;
    end

    // Outside a transaction the committed boundary follows the write pointer
    if (wr_direct) begin
      commit_ptr_d = wr_ptr_d;
    end

    // Commit publishes everything written so far, including this cycle's write
    if (publish) begin
      commit_ptr_d = wr_ptr_d;
      count_d      = used_d;
    end

    // Abort drops every pending entry, including this cycle's write
    if (rewind) begin
      wr_ptr_d = commit_ptr_q;
      used_d   = count_d;
    end
  end

  // Sticky error collection; new errors win over a same-cycle clear
  always_comb begin
    err_set           = '0;
    err_set[ERR_OVR]  = bus.i_wr_en & ~wr_acc;
    err_set[ERR_UNR]  = bus.i_rd_en & ~rd_acc;
    err_set[ERR_NEST] = err_nest;
    err_set[ERR_IDLE] = err_idle;
    err_set[ERR_CONF] = ctrl_conflict;
    err_d = (bus.i_clr_err ? '0 : err_q) | err_set;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      used_q       <= '0;
      err_q        <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
      used_q       <= used_d;
      err_q        <= err_d;
    end
  end

  circ_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.i_wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Outputs: all status is decoded from registered state
  assign bus.o_rd_data      = rd_data;
  assign bus.o_rd_valid     = (count_q != '0);
  assign bus.o_count        = count_q;
  assign bus.o_used         = used_q;
  assign bus.o_full         = (used_q == DEPTH_C);
  assign bus.o_empty        = (count_q == '0);
  assign bus.o_almost_full  = (used_q >= AF_C);
  assign bus.o_almost_empty = (count_q <= AE_C);
  assign bus.o_txn_open     = (state_q == ST_OPEN);
  assign bus.o_err          = err_q;
  assign bus.o_state        = state_q;

endmodule

// File: tb/tb_txn_circular_buffer.sv
// Bench for txn_circular_buffer with DEPTH=8. A queue-based reference model
// tracks committed and pending entries, transaction state and sticky errors.
module tb_txn_circular_buffer;
  import txn_cb_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Reference model: committed entries (reader-visible) and pending entries
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  bit         m_open;
  logic [4:0] m_err;

  txn_circular_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  txn_circular_buffer #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model update for one clock edge, written from the buffer's rules
  task automatic model_update(input bit r, input bit b, input bit c, input bit a,
                              input bit w, input logic [7:0] d, input bit rd, input bit cl);
    bit         conflict;
    bit         rd_ok;
    bit         wr_ok;
    int         used;
    logic [4:0] set;
    if (r) begin
      exp_q.delete();
      pend_q.delete();
      m_open = 1'b0;
      m_err  = '0;
      return;
    end
    set      = '0;
    conflict = (int'(b) + int'(c) + int'(a)) > 1;
    used     = exp_q.size() + pend_q.size();
    rd_ok    = rd && (exp_q.size() != 0);
    wr_ok    = w && ((used < 8) || rd_ok);
    if (rd && !rd_ok) set[1] = 1'b1;
    if (w && !wr_ok)  set[0] = 1'b1;
    if (rd_ok) void'(exp_q.pop_front());
    if (wr_ok) begin
      if (!m_open && !(b && !conflict)) exp_q.push_back(d);
      else pend_q.push_back(d);
    end
    if (conflict) begin
      set[4] = 1'b1;
    end else if (b) begin
      if (m_open) set[2] = 1'b1;
      else m_open = 1'b1;
    end else if (c || a) begin
      if (!m_open) begin
        set[3] = 1'b1;
      end else begin
        if (c) begin
          foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
        end
        pend_q.delete();
        m_open = 1'b0;
      end
    end
    m_err = (cl ? 5'b0 : m_err) | set;
  endtask

  // Driver: apply inputs at the falling edge, update the model at the
  // rising edge, return at the next falling edge ready for sampling
  task automatic step(input bit r, input bit b, input bit c, input bit a,
                      input bit w, input logic [7:0] d, input bit rd, input bit cl);
    rst              = r;
    bus.i_txn_begin  = b;
    bus.i_txn_commit = c;
    bus.i_txn_abort  = a;
    bus.i_wr_en      = w;
    bus.i_wr_data    = d;
    bus.i_rd_en      = rd;
    bus.i_clr_err    = cl;
    @(posedge clk);
    model_update(r, b, c, a, w, d, rd, cl);
    @(negedge clk);
    rst              = 1'b0;
    bus.i_txn_begin  = 1'b0;
    bus.i_txn_commit = 1'b0;
    bus.i_txn_abort  = 1'b0;
    bus.i_wr_en      = 1'b0;
    bus.i_rd_en      = 1'b0;
    bus.i_clr_err    = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", bus.o_empty); end
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.o_rd_valid); end
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", bus.o_full); end
    checks++; if (bus.o_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b exp 1", bus.o_almost_empty); end
    checks++; if (bus.o_count !== 4'd0 || bus.o_used !== 4'd0) begin errors++; $display("FAIL reset_count: got count=%0d used=%0d exp 0/0", bus.o_count, bus.o_used); end
    checks++; if (bus.o_err !== 5'd0 || bus.o_txn_open !== 1'b0) begin errors++; $display("FAIL reset_err_open: got err=%b open=%b exp 00000/0", bus.o_err, bus.o_txn_open); end
  endtask

  task automatic test_idle_rw();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 0, 1, 8'h11, 0, 0);
    checks++; if (bus.o_count !== 4'd1) begin errors++; $display("FAIL idle_count1: got %0d exp 1", bus.o_count); end
    checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 8'h11) begin errors++; $display("FAIL idle_head1: got valid=%b data=%h exp 1/11", bus.o_rd_valid, bus.o_rd_data); end
    step(0, 0, 0, 0, 1, 8'h22, 0, 0);
    checks++; if (bus.o_count !== 4'd2) begin errors++; $display("FAIL idle_count2: got %0d exp 2", bus.o_count); end
    step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    checks++; if (bus.o_rd_data !== 8'h22) begin errors++; $display("FAIL idle_head2: got %h exp 22", bus.o_rd_data); end
    step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    checks++; if (bus.o_empty !== 1'b1 || bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL idle_drained: got empty=%b valid=%b exp 1/0", bus.o_empty, bus.o_rd_valid); end
  endtask

  task automatic test_full();
    logic [7:0] exp_a[8];
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 8'h30 + 8'(i), 0, 0);
    checks++; if (bus.o_full !== 1'b1 || bus.o_used !== 4'd8 || bus.o_almost_full !== 1'b1) begin errors++; $display("FAIL full_flags: got full=%b used=%0d af=%b exp 1/8/1", bus.o_full, bus.o_used, bus.o_almost_full); end
    step(0, 0, 0, 0, 1, 8'hEE, 0, 0);
    checks++; if (bus.o_err !== 5'b00001 || bus.o_used !== 4'd8) begin errors++; $display("FAIL full_overrun: got err=%b used=%0d exp 00001/8", bus.o_err, bus.o_used); end
    step(0, 0, 0, 0, 1, 8'h77, 1, 0);
    checks++; if (bus.o_count !== 4'd8 || bus.o_used !== 4'd8) begin errors++; $display("FAIL full_rw: got count=%0d used=%0d exp 8/8", bus.o_count, bus.o_used); end
    exp_a = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h77};
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.o_rd_data !== exp_a[i]) begin errors++; $display("FAIL full_drain[%0d]: got %h exp %h", i, bus.o_rd_data, exp_a[i]); end
      step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL full_empty_after: got %b exp 1", bus.o_empty); end
  endtask

  task automatic test_txn_commit();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 1, 8'hA0, 0, 0);
    checks++; if (bus.o_state !== ST_OPEN) begin errors++; $display("FAIL commit_state: got %0d exp %0d", bus.o_state, ST_OPEN); end
    step(0, 0, 0, 0, 1, 8'hA1, 0, 0);
    step(0, 0, 0, 0, 1, 8'hA2, 0, 0);
    checks++; if (bus.o_count !== 4'd0 || bus.o_used !== 4'd3 || bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL commit_pending: got count=%0d used=%0d valid=%b exp 0/3/0", bus.o_count, bus.o_used, bus.o_rd_valid); end
    step(0, 0, 1, 0, 0, 8'h00, 0, 0);
    checks++; if (bus.o_count !== 4'd3 || bus.o_rd_data !== 8'hA0 || bus.o_txn_open !== 1'b0) begin errors++; $display("FAIL commit_publish: got count=%0d data=%h open=%b exp 3/a0/0", bus.o_count, bus.o_rd_data, bus.o_txn_open); end
  endtask

  task automatic test_abort();
    logic [7:0] exp_a[3];
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 0, 1, 8'h01, 0, 0);
    step(0, 0, 0, 0, 1, 8'h02, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'hB0 + 8'(i), 0, 0);
    checks++; if (bus.o_used !== 4'd5 || bus.o_count !== 4'd2) begin errors++; $display("FAIL abort_pre: got used=%0d count=%0d exp 5/2", bus.o_used, bus.o_count); end
    step(0, 0, 0, 1, 0, 8'h00, 0, 0);
    checks++; if (bus.o_used !== 4'd2 || bus.o_txn_open !== 1'b0 || bus.o_err !== 5'd0) begin errors++; $display("FAIL abort_rewind: got used=%0d open=%b err=%b exp 2/0/00000", bus.o_used, bus.o_txn_open, bus.o_err); end
    step(0, 0, 0, 0, 1, 8'h55, 0, 0);
    exp_a = '{8'h01, 8'h02, 8'h55};
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.o_rd_data !== exp_a[i]) begin errors++; $display("FAIL abort_read[%0d]: got %h exp %h", i, bus.o_rd_data, exp_a[i]); end
      step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    end
  endtask

  task automatic test_errors();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 0, 0, 8'h00, 0, 0);
    checks++; if (bus.o_err !== 5'b01000) begin errors++; $display("FAIL err_idle: got %b exp 01000", bus.o_err); end
    step(0, 0, 0, 0, 0, 8'h00, 0, 1);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    checks++; if (bus.o_err !== 5'b00100 || bus.o_txn_open !== 1'b1) begin errors++; $display("FAIL err_nest: got err=%b open=%b exp 00100/1", bus.o_err, bus.o_txn_open); end
    step(0, 0, 0, 0, 0, 8'h00, 0, 1);
    step(0, 1, 0, 1, 0, 8'h00, 0, 0);
    checks++; if (bus.o_err !== 5'b10000 || bus.o_txn_open !== 1'b1) begin errors++; $display("FAIL err_conflict: got err=%b open=%b exp 10000/1", bus.o_err, bus.o_txn_open); end
    step(0, 0, 0, 0, 0, 8'h00, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    checks++; if (bus.o_err !== 5'b00010) begin errors++; $display("FAIL err_underrun: got %b exp 00010", bus.o_err); end
    step(0, 0, 0, 0, 0, 8'h00, 0, 1);
    checks++; if (bus.o_err !== 5'b00000) begin errors++; $display("FAIL err_clear: got %b exp 00000", bus.o_err); end
    // A new error in the clearing cycle survives the clear
    step(0, 0, 0, 0, 0, 8'h00, 1, 1);
    checks++; if (bus.o_err !== 5'b00010) begin errors++; $display("FAIL err_clr_priority: got %b exp 00010", bus.o_err); end
  endtask

  task automatic test_wrap_and_reset();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 8'hC0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'h60 + 8'(i), 0, 0);
    step(0, 0, 1, 0, 0, 8'h00, 0, 0);
    checks++; if (bus.o_count !== 4'd5) begin errors++; $display("FAIL wrap_count: got %0d exp 5", bus.o_count); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.o_rd_data !== 8'h60 + 8'(i)) begin errors++; $display("FAIL wrap_read[%0d]: got %h exp %h", i, bus.o_rd_data, 8'h60 + 8'(i)); end
      step(0, 0, 0, 0, 0, 8'h00, 1, 0);
    end
    step(0, 1, 0, 0, 1, 8'h99, 0, 0);
    step(1, 0, 0, 0, 1, 8'h98, 0, 0);
    checks++; if (bus.o_txn_open !== 1'b0 || bus.o_used !== 4'd0 || bus.o_count !== 4'd0) begin errors++; $display("FAIL midtxn_reset: got open=%b used=%0d count=%0d exp 0/0/0", bus.o_txn_open, bus.o_used, bus.o_count); end
    checks++; if (bus.o_empty !== 1'b1 || bus.o_almost_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_err !== 5'd0) begin errors++; $display("FAIL midtxn_reset_flags: got empty=%b ae=%b full=%b err=%b exp 1/1/0/00000", bus.o_empty, bus.o_almost_empty, bus.o_full, bus.o_err); end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit         r, b, c, a, w, rd, cl;
      logic [7:0] d;
      logic [3:0] e_cnt;
      logic [3:0] e_used;
      r  = ($urandom_range(0, 249) == 0);
      b  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 13) == 0);
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 11) == 0);
      d  = 8'($urandom_range(0, 255));
      step(r, b, c, a, w, d, rd, cl);
      e_cnt  = 4'(exp_q.size());
      e_used = 4'(exp_q.size() + pend_q.size());
      checks++; if (bus.o_count !== e_cnt || bus.o_used !== e_used) begin errors++; $display("FAIL rand_occ[%0d]: got count=%0d used=%0d exp %0d/%0d", i, bus.o_count, bus.o_used, e_cnt, e_used); end
      if (e_cnt != 0) begin
        checks++; if (bus.o_rd_data !== exp_q[0]) begin errors++; $display("FAIL rand_head[%0d]: got %h exp %h", i, bus.o_rd_data, exp_q[0]); end
      end
      checks++; if (bus.o_rd_valid !== (e_cnt != 0) || bus.o_empty !== (e_cnt == 0)) begin errors++; $display("FAIL rand_valid[%0d]: got valid=%b empty=%b exp cnt=%0d", i, bus.o_rd_valid, bus.o_empty, e_cnt); end
      checks++; if (bus.o_full !== (e_used == 4'd8) || bus.o_almost_full !== (e_used >= 4'd6) || bus.o_almost_empty !== (e_cnt <= 4'd1)) begin errors++; $display("FAIL rand_flags[%0d]: got full=%b af=%b ae=%b exp used=%0d cnt=%0d", i, bus.o_full, bus.o_almost_full, bus.o_almost_empty, e_used, e_cnt); end
      checks++; if (bus.o_txn_open !== m_open || bus.o_err !== m_err) begin errors++; $display("FAIL rand_ctrl[%0d]: got open=%b err=%b exp %b/%b", i, bus.o_txn_open, bus.o_err, m_open, m_err); end
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    m_open           = 1'b0;
    m_err            = '0;
    rst              = 1'b1;
    bus.i_txn_begin  = 1'b0;
    bus.i_txn_commit = 1'b0;
    bus.i_txn_abort  = 1'b0;
    bus.i_wr_en      = 1'b0;
    bus.i_wr_data    = '0;
    bus.i_rd_en      = 1'b0;
    bus.i_clr_err    = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_rw();
    test_full();
    test_txn_commit();
    test_abort();
    test_errors();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
